// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the keypad matrix scanner.
package keypad_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    SAMPLE = ST_SAMPLE
  } scan_state_t;

  // Column settle time in clocks, never less than one.
  function automatic int settle_clk(input int ns, input int mhz);
    int c;
    c = (ns * mhz) / 1000;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int scans);
    return $clog2(scans + 1);
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module key_event_fifo
  import keypad_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && full_o && !do_pop;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // When full, the write slot is the head being popped this cycle, so the overwrite is safe.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Column-scanning keypad controller with per-key debounce and a press-event FIFO.
// Handshake: an entry moves on key_valid_o && key_ready_i; key_code_o is stable while key_valid_o waits for key_ready_i.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int CLK_FREQ_MHZ   = 20,
  parameter int SETTLE_TIME_NS = 1000,
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                enable_i,
  input  logic [ROWS-1:0]                     row_i,
  output logic [COLS-1:0]                     col_o,
  output logic                                key_valid_o,
  output logic [idx_width(ROWS*COLS)-1:0]     key_code_o,
  input  logic                                key_ready_i,
  output logic                                overflow_o,
  input  logic                                overflow_clr_i
);

  localparam int SETTLE_CYC = settle_clk(SETTLE_TIME_NS, CLK_FREQ_MHZ) + 2;
  localparam int NKEYS      = ROWS * COLS;
  localparam int KW         = idx_width(NKEYS);
  localparam int CW         = cnt_width(DEBOUNCE_SCANS);
  localparam int TW         = $clog2(SETTLE_CYC);
  localparam int RIW        = idx_width(ROWS);
  localparam int CIW        = idx_width(COLS);

  localparam logic [TW-1:0]  TIMER_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [RIW-1:0] ROW_LAST   = RIW'(ROWS - 1);
  localparam logic [CIW-1:0] COL_LAST   = CIW'(COLS - 1);
  localparam logic [CW:0]    CNT_LIMIT  = (CW + 1)'(DEBOUNCE_SCANS);

  logic [ROWS-1:0]            sync1_q, sync2_q;
  logic [ROWS-1:0]            rows_q, rows_d;
  scan_state_t                state_q, state_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic [CIW-1:0]             col_q, col_d;
  logic [RIW-1:0]             row_q, row_d;
  logic [NKEYS-1:0]           stable_q, stable_d;
  logic [NKEYS-1:0][CW-1:0]   cnt_q, cnt_d;
  logic                       overflow_q, overflow_d;
  logic                       eval;
  logic                       push;
  logic                       sample;
  logic [CW:0]                cnt_inc;
  logic [KW-1:0]              key_idx;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       fifo_drop;
  logic                       fifo_pop;

  assign key_idx = KW'(int'(col_q) * ROWS + int'(row_q));
  assign sample  = rows_q[row_q];

  always_comb begin
    col_o = '1;
    if (state_q != IDLE) begin
      col_o[col_q] = 1'b0;
    end
  end

  // Disable overrides every state; going through IDLE restarts the scan at column 0.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    col_d   = col_q;
    row_d   = row_q;
    rows_d  = rows_q;
    eval    = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SETTLE;
          col_d   = '0;
          timer_d = '0;
        end
        SETTLE: begin
          if (timer_q == TIMER_LAST) begin
            rows_d  = sync2_q;
            row_d   = '0;
            state_d = SAMPLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        SAMPLE: begin
          eval = 1'b1;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            timer_d = '0;
            state_d = SETTLE;
            col_d   = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating debounce: only a run of DEBOUNCE_SCANS differing samples flips the stable state.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    push     = 1'b0;
    cnt_inc  = {1'b0, cnt_q[key_idx]} + 1'b1;
    if (eval) begin
      if (sample == stable_q[key_idx]) begin
        cnt_d[key_idx] = '0;
      end else if (cnt_inc == CNT_LIMIT) begin
        stable_d[key_idx] = sample;
        cnt_d[key_idx]    = '0;
        push              = sample;
      end else begin
        cnt_d[key_idx] = cnt_inc[CW-1:0];
      end
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (fifo_drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      rows_q     <= '0;
      state_q    <= IDLE;
      timer_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      stable_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= ~row_i;
      sync2_q    <= sync1_q;
      rows_q     <= rows_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      col_q      <= col_d;
      row_q      <= row_d;
      stable_q   <= stable_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign fifo_pop    = key_valid_o && key_ready_i;
  assign key_valid_o = !fifo_empty;
  assign overflow_o  = overflow_q;

  key_event_fifo #(
    .WIDTH (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (key_idx),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop),
    .head_o      (key_code_o)
  );

  // Full is folded into drop/accept inside the FIFO; kept here for checker binding.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl at default parameters (scan period 104, column 26, eval pos = col*26+22+row).
module tb_keypad_scan_ctrl;

  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int KW     = 4;
  localparam int PERIOD = 104;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [ROWS-1:0] row_i;
  logic [COLS-1:0] col_o;
  logic            key_valid;
  logic [KW-1:0]   key_code;
  logic            key_ready;
  logic            overflow;
  logic            overflow_clr;
  logic [15:0]     pressed;
  logic [3:0]      exp_col;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int seen     = 0;
  logic [KW-1:0] exp_q[$];

  always #5 clk = ~clk;

  // Ideal matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_i = '1;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (!col_o[c] && pressed[c*ROWS+r]) row_i[r] = 1'b0;
      end
    end
  end

  keypad_scan_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .row_i          (row_i),
    .col_o          (col_o),
    .key_valid_o    (key_valid),
    .key_code_o     (key_code),
    .key_ready_i    (key_ready),
    .overflow_o     (overflow),
    .overflow_clr_i (overflow_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int pos();
    return (cyc - 1) % PERIOD;
  endfunction

  task automatic run_to(input int p);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (pos() != p && n < 2*PERIOD);
    chk("run_to_bound", pos(), p);
  endtask

  task automatic wait_scans(input int n);
    repeat (n*PERIOD) tick();
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      chk({tag, "_valid"}, key_valid, 1);
      chk({tag, "_code"}, key_code, exp_q.pop_front());
      key_ready = 1'b1;
      tick();
      key_ready = 1'b0;
    end
    chk({tag, "_empty"}, key_valid, 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; key_ready = 1'b0; overflow_clr = 1'b0; pressed = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_col", col_o, 4'hF);
    chk("reset_valid", key_valid, 0);
    chk("reset_code", key_code, 0);
    chk("reset_ovf", overflow, 0);
    rst = 1'b0;
    tick();
    chk("idle_col", col_o, 4'hF);

    // Column sequence over one full scan.
    enable = 1'b1;
    cyc = 0;
    for (int i = 0; i < PERIOD; i++) begin
      tick();
      exp_col = ~(4'b0001 << (i / 26));
      chk("scan_col", col_o, exp_col);
      chk("scan_valid", key_valid, 0);
    end
    tick();
    chk("scan_wrap", col_o, 4'b1110);

    // Held key 9 (row1/col2): one event on the third scan, never repeated.
    pressed[9] = 1'b1;
    run_to(76); chk("hold_s1", key_valid, 0);
    run_to(76); chk("hold_s2", key_valid, 0);
    run_to(75); chk("hold_s3_early", key_valid, 0);
    run_to(76); chk("hold_s3_valid", key_valid, 1);
    chk("hold_s3_code", key_code, 9);
    key_ready = 1'b1; tick(); key_ready = 1'b0;
    chk("hold_pop", key_valid, 0);
    seen = 0;
    repeat (10*PERIOD) begin tick(); if (key_valid) seen++; end
    chk("hold_no_repeat", seen, 0);
    pressed[9] = 1'b0;
    seen = 0;
    repeat (4*PERIOD) begin tick(); if (key_valid) seen++; end
    chk("release_no_event", seen, 0);

    // Two-scan glitch on key 0, then a proper three-scan press.
    run_to(0); pressed[0] = 1'b1;
    run_to(23); chk("glitch_s1", key_valid, 0);
    run_to(23); chk("glitch_s2", key_valid, 0);
    run_to(0); pressed[0] = 1'b0;
    run_to(23); chk("glitch_s3", key_valid, 0);
    run_to(23); chk("glitch_s4", key_valid, 0);
    run_to(0); pressed[0] = 1'b1;
    run_to(23); chk("press0_s1", key_valid, 0);
    run_to(23); chk("press0_s2", key_valid, 0);
    run_to(22); chk("press0_s3_early", key_valid, 0);
    run_to(23); chk("press0_s3_valid", key_valid, 1);
    chk("press0_code", key_code, 0);
    key_ready = 1'b1; tick(); key_ready = 1'b0;
    chk("press0_pop", key_valid, 0);
    pressed[0] = 1'b0;
    wait_scans(3);
    chk("press0_release", key_valid, 0);

    // Five sequential presses with no consumer: fifth is dropped.
    for (int k = 1; k <= 5; k++) begin
      run_to(0);
      pressed[k] = 1'b1;
      wait_scans(3);
      pressed[k] = 1'b0;
      wait_scans(3);
    end
    chk("ovf_set", overflow, 1);
    exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    exp_q.push_back(4'd3); exp_q.push_back(4'd4);
    drain("ovf_drain");
    chk("ovf_sticky", overflow, 1);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("ovf_clear", overflow, 0);

    // Keys 1..5 together: FIFO full after key 4, key 5 pushes in the cycle a pop happens.
    run_to(0);
    pressed[5:1] = 5'b11111;
    wait_scans(2);
    run_to(49);
    chk("full_valid", key_valid, 1);
    chk("full_head", key_code, 1);
    key_ready = 1'b1; tick(); key_ready = 1'b0;
    chk("pushpop_ovf", overflow, 0);
    exp_q.push_back(4'd2); exp_q.push_back(4'd3);
    exp_q.push_back(4'd4); exp_q.push_back(4'd5);
    drain("pushpop_drain");
    chk("pushpop_ovf_after", overflow, 0);
    pressed = '0;
    wait_scans(3);
    chk("pushpop_release", key_valid, 0);

    // Async reset in SAMPLE with two entries queued.
    run_to(0);
    pressed[1] = 1'b1; pressed[2] = 1'b1;
    wait_scans(2);
    run_to(25);
    chk("prereset_valid", key_valid, 1);
    chk("prereset_code", key_code, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_col", col_o, 4'hF);
    chk("async_rst_valid", key_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    run_to(25); chk("postrst_s1", key_valid, 0);
    run_to(25); chk("postrst_s2", key_valid, 0);
    run_to(24); chk("postrst_s3_valid", key_valid, 1);
    chk("postrst_s3_code", key_code, 1);
    key_ready = 1'b1; tick(); key_ready = 1'b0;
    chk("postrst_head2", key_code, 2);

    // Disable mid-SETTLE (column 1), FIFO contents survive, re-enable restarts at column 0.
    run_to(30);
    enable = 1'b0;
    tick();
    chk("disable_col", col_o, 4'hF);
    chk("disable_valid", key_valid, 1);
    chk("disable_code", key_code, 2);
    repeat (3) tick();
    chk("disable_col_hold", col_o, 4'hF);
    enable = 1'b1;
    cyc = 0;
    tick();
    chk("reenable_col0", col_o, 4'b1110);
    exp_q.push_back(4'd2);
    drain("retain_drain");
    pressed = '0;
    wait_scans(3);
    chk("final_valid", key_valid, 0);
    chk("final_ovf", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Scans a ROWS x COLS key matrix.
- Drives one column at a time and waits for settling.
- Debounces every key with per-key saturating counters in one shared sequencer.
- Pushes press events (key codes) into a small FIFO read out through a valid/ready interface.
- Sits between board-level keypad pins and the user-logic command decoder. It replaces one shift-register debouncer per discrete key.

Parameters:
- CLK_FREQ_MHZ, 20, clock frequency in MHz.
- SETTLE_TIME_NS, 1000, column settle time. SETTLE_CLK = max(1, SETTLE_TIME_NS*CLK_FREQ_MHZ/1000); default 20.
- ROWS, 4, matrix rows, 1..8.
- COLS, 4, matrix columns, 1..8.
- DEBOUNCE_SCANS, 3, consecutive differing samples required to change a key's stable state, 1..15.
- FIFO_DEPTH, 4, event FIFO entries, power of two >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  scanning enabled.
- row_i  in  ROWS  raw row inputs, active-low (0 = pressed), asynchronous to clk_i.
- col_o  out  COLS  column drive, active-low one-hot; all ones when idle.
- key_valid_o  out  1  FIFO head valid.
- key_code_o  out  KW=$clog2(ROWS*COLS)  key code = col*ROWS + row.
- key_ready_i  in  1  consumer accepts head.
- overflow_o  out  1  sticky: a press event was dropped.
- overflow_clr_i  in  1  clears overflow_o.

Behaviour:
- Reset (async, rst_i=1):
  - col_o = all ones, key_valid_o = 0, key_code_o = 0, overflow_o = 0.
  - FIFO empty.
  - All keys stable = released; all counters = 0.
  - FSM = IDLE, column index = 0.
- Input sync: row_i passes through a 2-flop synchronizer, inverted so 1 = pressed.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE:
  - col_o all ones.
  - Goes to SETTLE with column 0 when enable_i = 1.
- SETTLE:
  - col_o drives the current column low.
  - Waits exactly SETTLE_CLK+2 cycles (the 2 cycles cover synchronizer latency).
  - Then goes to SAMPLE.
  - The synchronized row vector is latched on the last SETTLE cycle.
- SAMPLE:
  - Lasts ROWS cycles, evaluating one row per cycle in order 0..ROWS-1 against the latched vector.
  - col_o is held.
  - After row ROWS-1: column increments, wraps COLS-1 -> 0, and the FSM goes to SETTLE.
- Scan period = COLS*(SETTLE_CLK+2+ROWS) cycles; 104 at defaults.
- Per-key debounce on evaluation:
  - If sample == stable, counter <= 0.
  - Else counter+1. If it reaches DEBOUNCE_SCANS: stable <= sample, counter <= 0.
  - If the new stable value is pressed, issue a push request with that key's code in the same cycle.
  - Release transitions update state only; no event.
  - A held key never repeats.
- enable_i deasserted in any state:
  - FSM goes to IDLE next cycle and col_o becomes all ones.
  - Per-key state and FIFO are retained.
  - Re-enable restarts at column 0.
- FIFO:
  - Standard synchronous FIFO, first-word-fall-through.
  - key_valid_o = !empty; key_code_o = head.
  - Pop when key_valid_o && key_ready_i.
  - Push accepted when !full, or when full with a pop in the same cycle.
  - Push rejected (full, no pop): event dropped, overflow_o <= 1.
  - If overflow_clr_i and a drop occur in the same cycle, overflow_o = 1 (set wins).
- Latency: FIFO entry is visible on key_valid_o the cycle after the accepting SAMPLE cycle.
- Ghosting from multiple simultaneous presses is not compensated.

Decomposition:
- Package keypad_pkg holds:
  - enum scan_state_t {IDLE, SETTLE, SAMPLE}.
  - Function settle_clk(ns, mhz), including the clamp to 1.
  - Localparam helpers for KW and counter width $clog2(DEBOUNCE_SCANS+1).
- Sub-module key_event_fifo: parameterized width/depth, with push/pop/full/empty and same-cycle push-on-full-with-pop. The top holds the FSM, synchronizer and per-key register arrays.

Test Plan:
- Reset then enable_i=1 -> col_o sequence 1110,1101,1011,0111; each column held 26 cycles; period 104; key_valid_o stays 0.
- Hold key row1/col2 (row_i[1]=0 while col_o[2]=0) -> after exactly 3 sampled scans one event, key_code_o=9; holding for 10 more scans gives no further event.
- Glitch: key row0/col0 pressed for 2 scans then released -> no event; counter returns to 0; a later 3-scan press yields code 0.
- key_ready_i=0, press/release keys 1,2,3,4,5 sequentially -> FIFO holds 1,2,3,4; overflow_o=1; raising ready pops 1,2,3,4 in order; overflow_clr_i pulse clears overflow_o.
- Full FIFO, pop and push in the same cycle -> push accepted, overflow_o stays 0.
- Assert rst_i mid-SAMPLE with two FIFO entries -> immediately col_o=1111, key_valid_o=0; after release the still-held key produces a fresh event after 3 scans. Drop enable_i mid-SETTLE -> col_o=1111 next cycle, FIFO contents retained.
